// File: rtl/aes_pipeline_stage_ghash.sv
// rtl/aes_pipeline_stage_ghash.sv - AES-GCM final stage: GCTR XOR, iterative GHASH, tag output (optional GHASH_DECRYPT_EN)
module aes_pipeline_stage_ghash #(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:2]   i_phase,
  input  logic [0:127] i_h,
  input  logic [0:127] i_encrypted_j0,
  input  logic [0:127] i_encrypted_cb,
  input  logic [0:127] i_plain_text,
  input  logic [0:127] i_aad,
  input  logic [0:127] i_instance_size,
`ifdef GHASH_DECRYPT_EN
  input  logic         i_decrypt,
`endif
  output logic         o_ready,
  output logic [0:127] o_cipher_text,
  output logic         o_cipher_valid,
  output logic [0:127] o_tag,
  output logic         o_tag_valid,
  output logic         o_error
);

  localparam int N_CYC = 128 / BITS_PER_CYCLE;
  localparam int CNT_W = (N_CYC > 1) ? $clog2(N_CYC) : 1;
  localparam logic [0:127] R_POLY = {8'he1, 120'd0};

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [0:127]       x_q, x_d, v_q, v_d, z_q, z_d, y_q, y_d, j0_q, j0_d;
  logic [0:127]       cipher_q, cipher_d, tag_q, tag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               len_q, len_d;
  logic               cipher_valid_q, cipher_valid_d;
  logic               tag_valid_q, tag_valid_d;
  logic               error_q, error_d;

  logic               blk_w;
  logic               dec_w;
  logic [0:127]       ghash_in;
  logic [0:127]       z_t, v_t;
  logic [6:0]         bit_idx;

`ifdef GHASH_DECRYPT_EN
  assign dec_w = i_decrypt;
`else
  assign dec_w = 1'b0;
`endif

  assign blk_w = (i_phase == 3'd1) || (i_phase == 3'd2) || (i_phase == 3'd3);

  // Next-state: accept/drop decisions, BITS_PER_CYCLE multiply steps, completion
  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    v_d            = v_q;
    z_d            = z_q;
    y_d            = y_q;
    j0_d           = j0_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    cipher_d       = cipher_q;
    tag_d          = tag_q;
    cipher_valid_d = 1'b0;
    tag_valid_d    = 1'b0;
    error_d        = error_q;
    ghash_in       = '0;
    z_t            = z_q;
    v_t            = v_q;
    bit_idx        = '0;

    // Decrypt feeds the received ciphertext straight into GHASH
    if (i_phase == 3'd1)      ghash_in = i_aad;
    else if (i_phase == 3'd2) ghash_in = dec_w ? i_plain_text : (i_plain_text ^ i_encrypted_cb);
    else if (i_phase == 3'd3) ghash_in = i_instance_size;

    // Bit 0 of X is the most significant GCM coefficient and is consumed first
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      bit_idx = 7'(int'(cnt_q) * BITS_PER_CYCLE + j);
      if (x_q[bit_idx]) z_t = z_t ^ v_t;
      v_t = v_t[127] ? ({1'b0, v_t[0:126]} ^ R_POLY) : {1'b0, v_t[0:126]};
    end

    case (state_q)
      S_IDLE: begin
        if (blk_w) begin
          x_d     = y_q ^ ghash_in;
          v_d     = i_h;
          z_d     = '0;
          cnt_d   = '0;
          len_d   = (i_phase == 3'd3);
          state_d = S_MULT;
          if (i_phase == 3'd3) j0_d = i_encrypted_j0;
          if (i_phase == 3'd2) begin
            cipher_d       = i_plain_text ^ i_encrypted_cb;
            cipher_valid_d = 1'b1;
          end
        end
      end
      S_MULT: begin
        z_d   = z_t;
        v_d   = v_t;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_CYC - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (len_q) begin
          y_d         = '0;
          tag_d       = z_q ^ j0_q;
          tag_valid_d = 1'b1;
        end else begin
          y_d = z_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Blocks arriving while busy are dropped; the running multiply is untouched
    if (state_q != S_IDLE && blk_w) error_d = 1'b1;
  end

  // State and datapath registers; reset aborts any multiply in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      x_q            <= '0;
      v_q            <= '0;
      z_q            <= '0;
      y_q            <= '0;
      j0_q           <= '0;
      cnt_q          <= '0;
      len_q          <= 1'b0;
      cipher_q       <= '0;
      tag_q          <= '0;
      cipher_valid_q <= 1'b0;
      tag_valid_q    <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      v_q            <= v_d;
      z_q            <= z_d;
      y_q            <= y_d;
      j0_q           <= j0_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      cipher_q       <= cipher_d;
      tag_q          <= tag_d;
      cipher_valid_q <= cipher_valid_d;
      tag_valid_q    <= tag_valid_d;
      error_q        <= error_d;
    end
  end

  assign o_ready        = (state_q == S_IDLE);
  assign o_cipher_text  = cipher_q;
  assign o_cipher_valid = cipher_valid_q;
  assign o_tag          = tag_q;
  assign o_tag_valid    = tag_valid_q;
  assign o_error        = error_q;

endmodule
